pipeline_feeder: RTL and testbench

PIPELINE_FEEDER -- requirements
Module: pipeline_feeder

---
 rtl/pipeline_hs_pkg.sv | 13 +
 rtl/pipeline_feeder.sv | 153 +++++++++++++++
 tb/tb_pipeline_feeder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hs_pkg.sv
// Shared widths and FSM state encoding for the pipeline operand feeder.
package pipeline_hs_pkg;
    localparam int OPW   = 8;
    localparam int GAP_W = 4;
    localparam int N_OPS = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/pipeline_feeder.sv
// Burst operand feeder: issues cmd_len operand sets (seed+k+j pattern) to a
// downstream pipeline with valid/ready handshake and optional idle gaps.
module pipeline_feeder #(
    parameter int OPW   = pipeline_hs_pkg::OPW,
    parameter int GAP_W = pipeline_hs_pkg::GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_len,
    input  logic [7:0]       cmd_seed,
    input  logic [GAP_W-1:0] cmd_gap,
    input  logic             abort,
    output logic [OPW-1:0]   a2,
    output logic [OPW-1:0]   a3,
    output logic [OPW-1:0]   a4,
    output logic [OPW-1:0]   b2,
    output logic [OPW-1:0]   b3,
    output logic [OPW-1:0]   b4,
    output logic [OPW-1:0]   c1,
    output logic [OPW-1:0]   c2,
    output logic [OPW-1:0]   c3,
    output logic [OPW-1:0]   c4,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy,
    output logic             done,
    output logic [7:0]       xfer_cnt
);
    import pipeline_hs_pkg::*;

    state_t           state;
    logic [7:0]       len_r;
    logic [7:0]       seed_r;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_cnt;
    logic             abort_f;
    logic [OPW-1:0]   ops    [N_OPS];
    logic [OPW-1:0]   ops_nx [N_OPS];
    logic [7:0]       base_nx;
    logic [7:0]       k_nx;
    logic             abort_pend;
    logic             last_xfer;

    assign abort_pend = abort_f | abort;
    assign last_xfer  = (xfer_cnt + 8'd1) == len_r;

    // Operand set to load on the next ISSUE entry: index 0 from IDLE,
    // the following index when streaming, the current count after a gap.
    always_comb begin
        base_nx = seed_r;
        k_nx    = xfer_cnt;
        if (state == S_IDLE) begin
            base_nx = cmd_seed;
            k_nx    = 8'd0;
        end else if (state == S_ISSUE) begin
            k_nx = xfer_cnt + 8'd1;
        end
        for (int j = 0; j < N_OPS; j++) begin
            ops_nx[j] = OPW'(base_nx) + OPW'(k_nx) + OPW'(j);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            valid_o   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
            xfer_cnt  <= 8'd0;
            abort_f   <= 1'b0;
            len_r     <= 8'd0;
            seed_r    <= 8'd0;
            gap_r     <= '0;
            gap_cnt   <= '0;
            for (int j = 0; j < N_OPS; j++) ops[j] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    abort_f <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        len_r     <= cmd_len;
                        seed_r    <= cmd_seed;
                        gap_r     <= cmd_gap;
                        xfer_cnt  <= 8'd0;
                        cmd_ready <= 1'b0;
                        if (cmd_len != 8'd0) begin
                            state   <= S_ISSUE;
                            valid_o <= 1'b1;
                            busy    <= 1'b1;
                            for (int j = 0; j < N_OPS; j++) ops[j] <= ops_nx[j];
                        end else begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    abort_f <= abort_pend;
                    if (valid_o && ready_i) begin
                        xfer_cnt <= xfer_cnt + 8'd1;
                        if (last_xfer || abort_pend) begin
                            state   <= S_FINISH;
                            valid_o <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (gap_r != '0) begin
                            state   <= S_GAP;
                            valid_o <= 1'b0;
                            gap_cnt <= gap_r;
                        end else begin
                            for (int j = 0; j < N_OPS; j++) ops[j] <= ops_nx[j];
                        end
                    end
                end
                S_GAP: begin
                    abort_f <= abort_pend;
                    if (abort_pend) begin
                        state <= S_FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        state   <= S_ISSUE;
                        valid_o <= 1'b1;
                        for (int j = 0; j < N_OPS; j++) ops[j] <= ops_nx[j];
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_FINISH: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    abort_f   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign a2 = ops[0];
    assign a3 = ops[1];
    assign a4 = ops[2];
    assign b2 = ops[3];
    assign b3 = ops[4];
    assign b4 = ops[5];
    assign c1 = ops[6];
    assign c2 = ops[7];
    assign c3 = ops[8];
    assign c4 = ops[9];
endmodule

// File: tb/tb_pipeline_feeder.sv
// Scoreboard bench for pipeline_feeder: directed bursts push expected operand
// sets and completion counts; a negedge monitor pops and compares.
module tb_pipeline_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_len = 8'd0;
    logic [7:0] cmd_seed = 8'd0;
    logic [3:0] cmd_gap = 4'd0;
    logic       abort = 1'b0;
    logic [7:0] a2, a3, a4, b2, b3, b4, c1, c2, c3, c4;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic       busy, done;
    logic [7:0] xfer_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [79:0] exp_q[$];
    logic [7:0]  done_q[$];
    logic [79:0] act_set;

    assign act_set = {c4, c3, c2, c1, b4, b3, b2, a4, a3, a2};

    always #5 clk = ~clk;

    pipeline_feeder dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_seed(cmd_seed), .cmd_gap(cmd_gap), .abort(abort),
        .a2(a2), .a3(a3), .a4(a4), .b2(b2), .b3(b3), .b4(b4),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4),
        .valid_o(valid_o), .ready_i(ready_i),
        .busy(busy), .done(done), .xfer_cnt(xfer_cnt)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] mk_set(input logic [7:0] s, input logic [7:0] k);
        logic [79:0] r;
        for (int j = 0; j < 10; j++) r[j*8 +: 8] = s + k + 8'(j);
        return r;
    endfunction

    task automatic push_sets(input logic [7:0] s, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(mk_set(s, 8'(k)));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic [7:0] seed, input logic [3:0] gap);
        int t;
        t = 0;
        while (!cmd_ready && t < 100) begin
            cyc();
            t++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 80'(cmd_ready), 80'(1));
        cmd_len   = len;
        cmd_seed  = seed;
        cmd_gap   = gap;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 100) begin
            cyc();
            t++;
        end
        chk(name, 80'(done), 80'(1));
    endtask

    // Monitor: a transfer happens at the next rising edge when valid_o && ready_i.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got set %0h expected none", act_set);
                end else begin
                    chk("xfer_ops", act_set, exp_q.pop_front());
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got xfer_cnt %0d expected no done", xfer_cnt);
                end else begin
                    chk("done_xfer_cnt", 80'(xfer_cnt), 80'(done_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] trace;
        int cnt;

        // reset
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_valid", 80'(valid_o), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_done", 80'(done), 80'(0));
        chk("rst_cmd_ready", 80'(cmd_ready), 80'(1));
        chk("rst_xfer_cnt", 80'(xfer_cnt), 80'(0));
        chk("rst_ops", act_set, 80'(0));

        // abort while idle must not affect the next burst
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        // back-to-back, gap 0
        ready_i = 1'b1;
        push_sets(8'h10, 3);
        done_q.push_back(8'd3);
        send_cmd(8'd3, 8'h10, 4'd0);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_valid", 80'(valid_o), 80'(1));
            if (i == 0) begin
                chk("b2b_t0_a2", 80'(a2), 80'(8'h10));
                chk("b2b_t0_c4", 80'(c4), 80'(8'h19));
            end
            if (i == 2) begin
                chk("b2b_t2_a2", 80'(a2), 80'(8'h12));
                chk("b2b_t2_c4", 80'(c4), 80'(8'h1B));
            end
            cyc();
        end
        chk("b2b_done", 80'(done), 80'(1));
        chk("b2b_valid_low", 80'(valid_o), 80'(0));
        chk("b2b_xfer_cnt", 80'(xfer_cnt), 80'(3));
        cyc();
        chk("b2b_done_pulse", 80'(done), 80'(0));
        chk("b2b_cmd_ready", 80'(cmd_ready), 80'(1));
        chk("b2b_hold_cnt", 80'(xfer_cnt), 80'(3));

        // backpressure, with command inputs changing mid-burst
        ready_i = 1'b0;
        push_sets(8'h40, 2);
        done_q.push_back(8'd2);
        send_cmd(8'd2, 8'h40, 4'd0);
        cmd_len  = 8'd9;
        cmd_seed = 8'h77;
        cmd_gap  = 4'd5;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 80'(valid_o), 80'(1));
            chk("bp_ops", act_set, {8'h49, 8'h48, 8'h47, 8'h46, 8'h45,
                                    8'h44, 8'h43, 8'h42, 8'h41, 8'h40});
            cyc();
        end
        ready_i = 1'b1;
        wait_done("bp_done");
        chk("bp_xfer_cnt", 80'(xfer_cnt), 80'(2));
        cyc();

        // gaps and operand wrap
        ready_i = 1'b1;
        push_sets(8'hFE, 3);
        done_q.push_back(8'd3);
        send_cmd(8'd3, 8'hFE, 4'd2);
        chk("wrap_a2", 80'(a2), 80'(8'hFE));
        chk("wrap_a4", 80'(a4), 80'(8'h00));
        chk("wrap_c4", 80'(c4), 80'(8'h07));
        for (int i = 0; i < 7; i++) begin
            trace[6-i] = valid_o;
            cyc();
        end
        chk("gap_trace", 80'(trace), 80'(7'b1001001));
        chk("gap_done", 80'(done), 80'(1));
        cyc();

        // abort while stalled at k=1
        ready_i = 1'b0;
        push_sets(8'h20, 2);
        done_q.push_back(8'd2);
        send_cmd(8'd5, 8'h20, 4'd0);
        ready_i = 1'b1;
        cyc();
        ready_i = 1'b0;
        abort   = 1'b1;
        cyc();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_hold_valid", 80'(valid_o), 80'(1));
            chk("abort_hold_a2", 80'(a2), 80'(8'h21));
            cyc();
        end
        ready_i = 1'b1;
        cyc();
        chk("abort_done", 80'(done), 80'(1));
        chk("abort_xfer_cnt", 80'(xfer_cnt), 80'(2));
        chk("abort_valid_low", 80'(valid_o), 80'(0));
        cyc();

        // abort during gap
        ready_i = 1'b1;
        push_sets(8'h30, 1);
        done_q.push_back(8'd1);
        send_cmd(8'd4, 8'h30, 4'd3);
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("gap_abort_done", 80'(done), 80'(1));
        chk("gap_abort_cnt", 80'(xfer_cnt), 80'(1));
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid_o) cnt++;
            cyc();
        end
        chk("gap_abort_no_valid", 80'(cnt), 80'(0));

        // zero-length command
        done_q.push_back(8'd0);
        send_cmd(8'd0, 8'h55, 4'd1);
        chk("zero_done", 80'(done), 80'(1));
        chk("zero_valid", 80'(valid_o), 80'(0));
        chk("zero_busy", 80'(busy), 80'(0));
        chk("zero_xfer_cnt", 80'(xfer_cnt), 80'(0));
        cyc();

        // reset mid-burst, with ready_i high during reset
        ready_i = 1'b0;
        send_cmd(8'd5, 8'h60, 4'd0);
        cyc();
        rst     = 1'b1;
        ready_i = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("mid_rst_valid", 80'(valid_o), 80'(0));
        chk("mid_rst_busy", 80'(busy), 80'(0));
        chk("mid_rst_cmd_ready", 80'(cmd_ready), 80'(1));
        chk("mid_rst_xfer_cnt", 80'(xfer_cnt), 80'(0));
        cyc();
        cyc();

        chk("exp_q_drained", 80'(exp_q.size()), 80'(0));
        chk("done_q_drained", 80'(done_q.size()), 80'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
